fsmseq_tx: RTL and testbench

//  Serial frame transmitter; the transmit end of the 1101-preamble serial link whose receiver

---
 rtl/fsmseq_tx.sv | 167 ++++++++++++++++
 tb/tb_fsmseq_tx.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fsmseq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fsmseq_tx : serial frame transmitter (preamble 1101, MSB-first payload,  |
// |             forced idle gap). Optional even parity: FSMSEQ_TX_PARITY_EN  |
// | Revision  : 1.0                                                          |
// +--------------------------------------------------------------------------+
module fsmseq_tx #(
  parameter int DATA_W = 4,
  parameter int GAP    = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              data,
  output logic              busy,
  output logic              done
);

  localparam int c_MAX_A = (DATA_W > 4) ? DATA_W : 4;
  localparam int c_MAX_B = (GAP > c_MAX_A) ? GAP : c_MAX_A;
  localparam int c_CNT_W = ($clog2(c_MAX_B) < 1) ? 1 : $clog2(c_MAX_B);

  localparam logic [c_CNT_W-1:0] c_PRE_LOAD = c_CNT_W'(3);
  localparam logic [c_CNT_W-1:0] c_PAY_LOAD = c_CNT_W'(DATA_W - 1);
  localparam logic [c_CNT_W-1:0] c_GAP_LOAD = c_CNT_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_CNT_W-1:0] c_CNT_TWO  = c_CNT_W'(2);

  localparam logic [2:0] c_ST_IDLE = 3'd0;
  localparam logic [2:0] c_ST_PRE  = 3'd1;
  localparam logic [2:0] c_ST_PAY  = 3'd2;
  localparam logic [2:0] c_ST_PAR  = 3'd3;
  localparam logic [2:0] c_ST_GAP  = 3'd4;

  // With GAP=0 the frame returns straight to IDLE after its last bit.
  localparam logic [2:0] c_POST_STATE = (GAP > 0) ? c_ST_GAP : c_ST_IDLE;

`ifdef FSMSEQ_TX_PARITY_EN
  localparam logic c_PAR_EN = 1'b1;
`else
  localparam logic c_PAR_EN = 1'b0;
`endif

  logic [2:0]         r_state;
  logic [2:0]         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic [DATA_W-1:0]  r_shreg;
  logic               r_data;
  logic               r_done;
  logic               w_data_nxt;
  logic               w_done_nxt;
  logic               w_load;
  logic               w_shift;
  logic               w_accept;

`ifdef FSMSEQ_TX_PARITY_EN
  logic r_parity;
`endif

  assign in_ready = (r_state == c_ST_IDLE);
  assign busy     = (r_state != c_ST_IDLE);
  assign data     = r_data;
  assign done     = r_done;
  assign w_accept = in_valid & in_ready;

  // State names the bit currently on the line; r_data/r_done are loaded with
  // the next bit so the line changes on the same edge as the state.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_data_nxt  = 1'b0;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    w_shift     = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = c_ST_PRE;
          w_cnt_nxt   = c_PRE_LOAD;
          w_data_nxt  = 1'b1;
          w_load      = 1'b1;
        end
      end
      c_ST_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_ST_PAY;
          w_cnt_nxt   = c_PAY_LOAD;
          w_data_nxt  = r_shreg[DATA_W-1];
          w_shift     = 1'b1;
          w_done_nxt  = !c_PAR_EN && (c_PAY_LOAD == '0);
        end else begin
          w_cnt_nxt  = r_cnt - c_CNT_ONE;
          w_data_nxt = (r_cnt != c_CNT_TWO);
        end
      end
      c_ST_PAY: begin
        if (r_cnt == '0) begin
`ifdef FSMSEQ_TX_PARITY_EN
          w_state_nxt = c_ST_PAR;
          w_data_nxt  = r_parity;
          w_done_nxt  = 1'b1;
`else
          w_state_nxt = c_POST_STATE;
          w_cnt_nxt   = c_GAP_LOAD;
`endif
        end else begin
          w_cnt_nxt  = r_cnt - c_CNT_ONE;
          w_data_nxt = r_shreg[DATA_W-1];
          w_shift    = 1'b1;
          w_done_nxt = !c_PAR_EN && (r_cnt == c_CNT_ONE);
        end
      end
`ifdef FSMSEQ_TX_PARITY_EN
      c_ST_PAR: begin
        w_state_nxt = c_POST_STATE;
        w_cnt_nxt   = c_GAP_LOAD;
      end
`endif
      c_ST_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = c_ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - c_CNT_ONE;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_ST_IDLE;
      r_cnt   <= '0;
      r_shreg <= '0;
      r_data  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_data  <= w_data_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_shreg <= in_data;
      end else if (w_shift) begin
        r_shreg <= r_shreg << 1;
      end
    end
  end

`ifdef FSMSEQ_TX_PARITY_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_parity <= 1'b0;
    end else if (w_load) begin
      r_parity <= ^in_data;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fsmseq_tx.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fsmseq_tx : randomized self-checking bench for fsmseq_tx against a     |
// |                frame-queue reference model                               |
// | Revision     : 1.0                                                       |
// +--------------------------------------------------------------------------+
module tb_fsmseq_tx;
  localparam int DATA_W = 4;
  localparam int GAP    = 2;
`ifdef FSMSEQ_TX_PARITY_EN
  localparam int c_FRAME = 5 + DATA_W;
`else
  localparam int c_FRAME = 4 + DATA_W;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_ready;
  logic              data;
  logic              busy;
  logic              done;

  fsmseq_tx #(.DATA_W(DATA_W), .GAP(GAP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .data     (data),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [1:0] m_q[$];          // {done, bit} for every non-idle line cycle still to come
  logic       m_busy = 1'b0;
  logic       m_data = 1'b0;
  logic       m_done = 1'b0;
  logic [3:0] rx_hist = 4'b0;  // last four line bits, as a 1101 hunter would see them

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // A frame is the preamble, the payload MSB-first, optional parity, then GAP zeros.
  task automatic model_edge();
    logic [3:0] pre;
    logic [1:0] e;
    pre = 4'b1101;
    if (!m_busy && in_valid) begin
      for (int i = 3; i >= 0; i--) m_q.push_back({1'b0, pre[i]});
      for (int i = DATA_W - 1; i >= 0; i--) m_q.push_back({(c_FRAME == 4 + DATA_W) && (i == 0), in_data[i]});
`ifdef FSMSEQ_TX_PARITY_EN
      m_q.push_back({1'b1, ^in_data});
`endif
      for (int i = 0; i < GAP; i++) m_q.push_back(2'b00);
    end
    if (m_q.size() > 0) begin
      e      = m_q.pop_front();
      m_busy = 1'b1;
      m_data = e[0];
      m_done = e[1];
    end else begin
      m_busy = 1'b0;
      m_data = 1'b0;
      m_done = 1'b0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("data",     32'(data),     32'(m_data));
    chk("done",     32'(done),     32'(m_done));
    chk("busy",     32'(busy),     32'(m_busy));
    chk("in_ready", 32'(in_ready), 32'(!m_busy));
    rx_hist = {rx_hist[2:0], data};
  endtask

  logic [7:0]     line;
  logic [GAP+1:0] seam;

  initial begin
    #2;
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #11 reset_n = 1'b1;

    repeat (4) step();
    chk("rx_idle", 32'(rx_hist), 32'd0);

    // Single frame 1010 with a stray in_valid pulse at cycle 3.
    in_valid = 1'b1;
    in_data  = 4'b1010;
    step();
    line     = {7'b0, data};
    in_valid = 1'b0;
    in_data  = DATA_W'($urandom);
    for (int k = 1; k < 8; k++) begin
      if (k == 3) begin
        in_valid = 1'b1;
        in_data  = 4'b0110;
      end
      step();
      if (k == 3) begin
        in_valid = 1'b0;
        chk("busy_rdy", 32'(in_ready), 32'd0);
        chk("rx_start", 32'(rx_hist), 32'hD);
      end
      line = {line[6:0], data};
    end
    chk("frame1", 32'(line), 32'hDA);
    repeat (GAP + 2) step();

    // Back-to-back frames with in_valid held: GAP+1 zeros, then the next preamble.
    in_valid = 1'b1;
    in_data  = 4'b1111;
    step();
    in_data = 4'b0001;
    seam    = '0;
    for (int k = 1; k <= c_FRAME + GAP + 1; k++) begin
      step();
      if (k >= c_FRAME) seam = {seam[GAP:0], data};
    end
    in_valid = 1'b0;
    chk("b2b_seam", 32'(seam), 32'd1);
    repeat (c_FRAME + GAP + 2) step();

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_data  = DATA_W'($urandom);
      step();
    end
    in_valid = 1'b0;
    repeat (c_FRAME + GAP + 2) step();

    // Asynchronous reset in the middle of a frame.
    in_valid = 1'b1;
    in_data  = 4'b1111;
    step();
    in_valid = 1'b0;
    repeat (6) step();
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_data", 32'(data), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    m_q.delete();
    m_busy = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
